qpsk_demodulator: RTL

Receive-side counterpart of the QPSK modulator. Accepts a stream of signed 16-bit I/Q baseband samples, integrates each rail over SPS samples per symbol (integrate-and-dump), slices the sign of each sum back to a 2-bit symbol, and buffers recovered symbols in a small FIFO with a valid/ready output. Sits between the channel/noise-filter path and the downstream bit sink; must exactly invert the modulator's dibit mapping.

---
 rtl/qpsk_pkg.sv | 22 ++
 rtl/qpsk_sym_fifo.sv | 66 ++++++
 rtl/qpsk_demodulator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: symbol levels, dibit type and the sign slicer,
// used by both the modulator and the demodulator so the mapping stays in lockstep.
package qpsk_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic signed [15:0] POS = 16'sh0001;
   localparam logic signed [15:0] NEG = 16'sh8000;

   typedef logic [1:0] dibit_t;

   typedef enum logic {
      ACCUM,
      HOLD
   } demod_state_t;

   // A negative rail sum maps to a 1 bit; zero decodes as 0.
   function automatic dibit_t slice(input logic i_sum_sign, input logic q_sum_sign);
      return {i_sum_sign, q_sum_sign};
   endfunction

endpackage

// File: rtl/qpsk_sym_fifo.sv
// Small dibit FIFO with a registered head word, so data_out comes straight
// from a flop and holds still while the consumer stalls.
module qpsk_sym_fifo
   import qpsk_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  dibit_t                 push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output dibit_t                 head
);

   localparam int AW = $clog2(DEPTH);

   dibit_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // The head is refreshed from the next stored entry on a pop, or taken
   // directly from the write port when the incoming word becomes the head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (pop_ok && (count > (AW+1)'(1))) begin
            head <= mem[rd_ptr + AW'(1)];
         end else if (push_ok && (empty || (pop_ok && (count == (AW+1)'(1))))) begin
            head <= push_data;
         end
      end
   end

endmodule

// File: rtl/qpsk_demodulator.sv
// Integrate-and-dump QPSK demodulator: sums SPS samples per rail, slices the
// signs to a dibit and queues recovered symbols behind a valid/ready port.
module qpsk_demodulator
   import qpsk_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SPS   = 4,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    s_align,
   input  logic signed [WIDTH-1:0] i_in,
   input  logic signed [WIDTH-1:0] q_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output dibit_t                  data_out,
   output logic                    align_err,
   output logic                    overrun
);

   localparam int ACC_W = (SPS > 1) ? WIDTH + $clog2(SPS) : WIDTH;
   localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

   demod_state_t            state_q;
   demod_state_t            state_d;
   logic signed [ACC_W-1:0] acc_i;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] base_i;
   logic signed [ACC_W-1:0] base_q;
   logic signed [ACC_W-1:0] sum_i;
   logic signed [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        base_cnt;
   logic                    accept;
   logic                    sym_done;
   logic                    pop_fire;
   logic                    becomes_full;
   logic                    pend_valid;
   dibit_t                  pend_dibit;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;

   assign s_ready  = (state_q == ACCUM);
   assign accept   = s_valid & s_ready;
   assign m_valid  = ~fifo_empty;
   assign pop_fire = m_valid & m_ready;

   // An aligned sample restarts the symbol, so it sums against zero at count 0.
   // The pending decision already owns a FIFO slot, hence its place in the fill test.
   always_comb begin
      base_i       = s_align ? '0 : acc_i;
      base_q       = s_align ? '0 : acc_q;
      base_cnt     = s_align ? '0 : cnt;
      sum_i        = base_i + ACC_W'(i_in);
      sum_q        = base_q + ACC_W'(q_in);
      sym_done     = accept && (base_cnt == LAST);
      becomes_full = (int'(fifo_count) + int'(pend_valid) - int'(pop_fire) + 1) == DEPTH;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCUM:   if (sym_done && becomes_full) state_d = HOLD;
         HOLD:    if (pop_fire) state_d = ACCUM;
         default: state_d = ACCUM;
      endcase
   end

   // The slicer output is registered before entering the FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_i      <= '0;
         acc_q      <= '0;
         cnt        <= '0;
         pend_valid <= 1'b0;
         pend_dibit <= '0;
         align_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         pend_valid <= sym_done;
         if (sym_done) begin
            pend_dibit <= slice(sum_i[ACC_W-1], sum_q[ACC_W-1]);
         end
         if (accept) begin
            if (base_cnt == LAST) begin
               acc_i <= '0;
               acc_q <= '0;
               cnt   <= '0;
            end else begin
               acc_i <= sum_i;
               acc_q <= sum_q;
               cnt   <= base_cnt + CNT_W'(1);
            end
         end
         align_err <= accept && s_align && (cnt != '0);
         if (s_valid && !s_ready) begin
            overrun <= 1'b1;
         end
      end
   end

   qpsk_sym_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pend_valid),
      .push_data (pend_dibit),
      .pop       (pop_fire),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (data_out)
   );

endmodule
